// File: rtl/rdma_demux_recv_pkg.sv
// Shared types and helpers for the RDMA receive demultiplexer.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
// Contents: req_t command, seq_t queue entry, beat_t data-fifo word, state_t,
//           is_opcode_rd_resp() classifier, beats_m1() beat-count helper.
package rdma_demux_recv_pkg;

  localparam int AXI_NET_BITS  = 512;
  localparam int AXI_KEEP_BITS = AXI_NET_BITS / 8;
  localparam int LEN_BITS      = 28;
  localparam int BEAT_LOG_BITS = 6;
  localparam int N_OUTSTANDING = 8;
  localparam int OPCODE_BITS   = 5;
  // One extra bit so the largest len still fits after the divide.
  localparam int CNT_BITS      = LEN_BITS - BEAT_LOG_BITS + 1;

  localparam logic [OPCODE_BITS-1:0] RC_RDMA_READ_RESP_FIRST  = 5'h0D;
  localparam logic [OPCODE_BITS-1:0] RC_RDMA_READ_RESP_MIDDLE = 5'h0E;
  localparam logic [OPCODE_BITS-1:0] RC_RDMA_READ_RESP_LAST   = 5'h0F;
  localparam logic [OPCODE_BITS-1:0] RC_RDMA_READ_RESP_ONLY   = 5'h10;

  typedef struct packed {
    logic [OPCODE_BITS-1:0] opcode;
    logic [LEN_BITS-1:0]    len;
    logic                   actv;
  } req_t;

  // Entry of the command sequence queue that steers the payload stream.
  typedef struct packed {
    logic                rd;
    logic                actv;
    logic [LEN_BITS-1:0] len;
  } seq_t;

  typedef struct packed {
    logic [AXI_NET_BITS-1:0]  tdata;
    logic [AXI_KEEP_BITS-1:0] tkeep;
    logic                     tlast;
  } beat_t;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_MUX  = 1'b1
  } state_t;

  function automatic logic is_opcode_rd_resp(input logic [OPCODE_BITS-1:0] opcode);
    return (opcode == RC_RDMA_READ_RESP_FIRST)  ||
           (opcode == RC_RDMA_READ_RESP_MIDDLE) ||
           (opcode == RC_RDMA_READ_RESP_LAST)   ||
           (opcode == RC_RDMA_READ_RESP_ONLY);
  endfunction

  // ceil(len/64)-1, valid for len != 0 (zero-length commands never reach the counter).
  function automatic logic [CNT_BITS-1:0] beats_m1(input logic [LEN_BITS-1:0] len);
    logic [LEN_BITS-1:0] len_m1;
    len_m1 = len - LEN_BITS'(1);
    return CNT_BITS'(len_m1 >> BEAT_LOG_BITS);
  endfunction

endpackage

// File: rtl/rdma_demux_recv_if.sv
// Handshake bundles used on the RDMA receive demultiplexer boundary.
// Latency: n/a (wires only).
// Backpressure: valid/ready on both bundles; transfer when both are high.
// Ports: meta bundle {valid, ready, data:req_t}; axis bundle {tvalid, tready,
//        tdata, tkeep, tlast}. Modport m drives valid/data, s drives ready.
interface rdma_demux_recv_meta_if;
  logic                       valid;
  logic                       ready;
  rdma_demux_recv_pkg::req_t  data;

  modport m (output valid, output data, input  ready);
  modport s (input  valid, input  data, output ready);
endinterface

interface rdma_demux_recv_axis_if;
  logic                                        tvalid;
  logic                                        tready;
  logic [rdma_demux_recv_pkg::AXI_NET_BITS-1:0]  tdata;
  logic [rdma_demux_recv_pkg::AXI_KEEP_BITS-1:0] tkeep;
  logic                                        tlast;

  modport m (output tvalid, output tdata, output tkeep, output tlast, input  tready);
  modport s (input  tvalid, input  tdata, input  tkeep, input  tlast, output tready);
endinterface

// File: rtl/rdma_demux_recv_fifo.sv
// Generic synchronous FIFO used for the sequence, command and data queues.
// Latency: 1 cycle from push to out_vld; full throughput with simultaneous push/pop.
// Backpressure: in_rdy low when full; out_dat held until out_rdy.
// Ports: aclk, aresetn (sync, active-low); in_vld/in_rdy/in_dat; out_vld/out_rdy/out_dat.
module rdma_demux_recv_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             in_vld,
  output logic             in_rdy,
  input  logic [WIDTH-1:0] in_dat,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [WIDTH-1:0] out_dat
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             push, pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  // Handshake outputs are forced low while reset is asserted.
  assign in_rdy  = aresetn && (cnt_q != (AW+1)'(DEPTH));
  assign out_vld = aresetn && (cnt_q != '0);
  assign out_dat = mem_q[rd_ptr_q];
  assign push    = in_vld && in_rdy;
  assign pop     = out_vld && out_rdy;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
    if (push && !pop)      cnt_d = cnt_q + (AW+1)'(1);
    else if (pop && !push) cnt_d = cnt_q - (AW+1)'(1);
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge aclk) begin
    if (push) mem_q[wr_ptr_q] <= in_dat;
  end

endmodule

// File: rtl/rdma_demux_recv.sv
// Steers the RDMA receive payload to the user write path or read-response path; drops duplicates.
// Latency: 1 cycle command->m_req_user, 1 cycle beat->output (through fifos); no bubble between packets.
// Backpressure: s_req_net stalls on full seq/cmd queue; s_axis_net stalls on the selected full data fifo.
// Ports: aclk, aresetn (sync, active-low); s_req_net (cmd in), m_req_user (WR cmd out);
//        s_axis_net (payload in); m_axis_user_wr / m_axis_user_rsp (payload out); err_len (sticky).
module rdma_demux_recv
  import rdma_demux_recv_pkg::*;
#(
  parameter int N_OST      = N_OUTSTANDING,
  parameter int REQ_DEPTH  = 4,
  parameter int DATA_DEPTH = 8
) (
  input  logic              aclk,
  input  logic              aresetn,
  rdma_demux_recv_meta_if.s s_req_net,
  rdma_demux_recv_meta_if.m m_req_user,
  rdma_demux_recv_axis_if.s s_axis_net,
  rdma_demux_recv_axis_if.m m_axis_user_wr,
  rdma_demux_recv_axis_if.m m_axis_user_rsp,
  output logic              err_len
);

  // ---------------- command side ----------------
  req_t req_in;
  seq_t seq_in, seq_out;
  logic cmd_rd, cmd_wr, cmd_fire;
  logic seq_in_rdy, seq_out_vld, seq_pop, reqq_in_rdy;

  assign req_in = s_req_net.data;
  assign cmd_rd = is_opcode_rd_resp(req_in.opcode);
  assign cmd_wr = req_in.actv && !cmd_rd;
  // Only WR commands need room in the user command queue; RSP and DROP do not.
  assign s_req_net.ready = seq_in_rdy && (!cmd_wr || reqq_in_rdy);
  assign cmd_fire = s_req_net.valid && s_req_net.ready;
  assign seq_in   = '{rd: cmd_rd, actv: req_in.actv, len: req_in.len};

  // Zero-length commands have no payload, so they never steer the data stream.
  rdma_demux_recv_fifo #(.WIDTH($bits(seq_t)), .DEPTH(N_OST)) u_seq_q (
    .aclk    (aclk),
    .aresetn (aresetn),
    .in_vld  (cmd_fire && (req_in.len != '0)),
    .in_rdy  (seq_in_rdy),
    .in_dat  (seq_in),
    .out_vld (seq_out_vld),
    .out_rdy (seq_pop),
    .out_dat (seq_out)
  );

  rdma_demux_recv_fifo #(.WIDTH($bits(req_t)), .DEPTH(REQ_DEPTH)) u_req_q (
    .aclk    (aclk),
    .aresetn (aresetn),
    .in_vld  (cmd_fire && cmd_wr),
    .in_rdy  (reqq_in_rdy),
    .in_dat  (req_in),
    .out_vld (m_req_user.valid),
    .out_rdy (m_req_user.ready),
    .out_dat (m_req_user.data)
  );

  // ---------------- data side ----------------
  state_t              state_q, state_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic                cur_rd_q, cur_rd_d;
  logic                cur_actv_q, cur_actv_d;
  logic                err_len_q, err_len_d;
  logic                in_mux, last_beat, beat_fire, sel_rdy;
  logic                wr_in_rdy, rsp_in_rdy;
  beat_t               beat_in, wr_out, rsp_out;

  assign in_mux    = aresetn && (state_q == ST_MUX);
  assign last_beat = (cnt_q == '0);

  // Duplicates are sunk unconditionally; live packets follow their fifo.
  always_comb begin
    sel_rdy = 1'b1;
    if (cur_actv_q) sel_rdy = cur_rd_q ? rsp_in_rdy : wr_in_rdy;
  end

  assign s_axis_net.tready = in_mux && sel_rdy;
  assign beat_fire         = s_axis_net.tvalid && s_axis_net.tready;
  // Output tlast comes from the command length, not from the network stream.
  assign beat_in = '{tdata: s_axis_net.tdata, tkeep: s_axis_net.tkeep, tlast: last_beat};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cur_rd_d   = cur_rd_q;
    cur_actv_d = cur_actv_q;
    seq_pop    = 1'b0;
    err_len_d  = err_len_q;

    if (beat_fire && (s_axis_net.tlast != last_beat)) err_len_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (seq_out_vld) begin
          seq_pop    = 1'b1;
          cur_rd_d   = seq_out.rd;
          cur_actv_d = seq_out.actv;
          cnt_d      = beats_m1(seq_out.len);
          state_d    = ST_MUX;
        end
      end
      ST_MUX: begin
        if (beat_fire) begin
          if (last_beat) begin
            // Chain straight into the next packet to avoid an idle cycle.
            if (seq_out_vld) begin
              seq_pop    = 1'b1;
              cur_rd_d   = seq_out.rd;
              cur_actv_d = seq_out.actv;
              cnt_d      = beats_m1(seq_out.len);
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            cnt_d = cnt_q - CNT_BITS'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      cur_rd_q   <= 1'b0;
      cur_actv_q <= 1'b0;
      err_len_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cur_rd_q   <= cur_rd_d;
      cur_actv_q <= cur_actv_d;
      err_len_q  <= err_len_d;
    end
  end

  assign err_len = err_len_q;

  rdma_demux_recv_fifo #(.WIDTH($bits(beat_t)), .DEPTH(DATA_DEPTH)) u_wr_q (
    .aclk    (aclk),
    .aresetn (aresetn),
    .in_vld  (in_mux && s_axis_net.tvalid && cur_actv_q && !cur_rd_q),
    .in_rdy  (wr_in_rdy),
    .in_dat  (beat_in),
    .out_vld (m_axis_user_wr.tvalid),
    .out_rdy (m_axis_user_wr.tready),
    .out_dat (wr_out)
  );

  rdma_demux_recv_fifo #(.WIDTH($bits(beat_t)), .DEPTH(DATA_DEPTH)) u_rsp_q (
    .aclk    (aclk),
    .aresetn (aresetn),
    .in_vld  (in_mux && s_axis_net.tvalid && cur_actv_q && cur_rd_q),
    .in_rdy  (rsp_in_rdy),
    .in_dat  (beat_in),
    .out_vld (m_axis_user_rsp.tvalid),
    .out_rdy (m_axis_user_rsp.tready),
    .out_dat (rsp_out)
  );

  assign m_axis_user_wr.tdata  = wr_out.tdata;
  assign m_axis_user_wr.tkeep  = wr_out.tkeep;
  assign m_axis_user_wr.tlast  = wr_out.tlast;
  assign m_axis_user_rsp.tdata = rsp_out.tdata;
  assign m_axis_user_rsp.tkeep = rsp_out.tkeep;
  assign m_axis_user_rsp.tlast = rsp_out.tlast;

endmodule

// File: tb/tb_rdma_demux_recv.sv
module tb_rdma_demux_recv;
  import rdma_demux_recv_pkg::*;

  localparam int TB_OST = 4;
  localparam logic [4:0] OP_WR  = 5'h0A;
  localparam logic [4:0] OP_RSP = 5'h10;

  typedef struct {
    logic [AXI_NET_BITS-1:0]  dat;
    logic [AXI_KEEP_BITS-1:0] keep;
    logic                     last;
    logic                     bad;
  } tb_beat_t;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  logic err_len;

  rdma_demux_recv_meta_if s_req_net ();
  rdma_demux_recv_meta_if m_req_user ();
  rdma_demux_recv_axis_if s_axis_net ();
  rdma_demux_recv_axis_if m_axis_user_wr ();
  rdma_demux_recv_axis_if m_axis_user_rsp ();

  rdma_demux_recv #(.N_OST(TB_OST)) dut (
    .aclk            (aclk),
    .aresetn         (aresetn),
    .s_req_net       (s_req_net),
    .m_req_user      (m_req_user),
    .s_axis_net      (s_axis_net),
    .m_axis_user_wr  (m_axis_user_wr),
    .m_axis_user_rsp (m_axis_user_rsp),
    .err_len         (err_len)
  );

  // Reference model state
  req_t     cmd_q[$];
  req_t     exp_req[$];
  tb_beat_t beat_plan[$];
  tb_beat_t exp_wr[$];
  tb_beat_t exp_rsp[$];
  logic     err_exp = 1'b0;
  int       hs_cyc[$];

  int n_cmp = 0, n_bad = 0;
  int cyc = 0;
  int wr_beats = 0, rsp_beats = 0, req_cnt = 0, hs_cnt = 0, cmd_acc = 0;
  int b_wr, b_rsp, b_req, b_hs;

  bit cmd_en = 1'b1, data_en = 1'b1, gaps = 1'b0;
  int wr_mode = 0, rsp_mode = 0, req_mode = 0;

  tb_beat_t e_wr, e_rsp;
  req_t     e_req;

  task automatic chk(input string tag, input logic [AXI_NET_BITS-1:0] got,
                     input logic [AXI_NET_BITS-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [AXI_NET_BITS-1:0] rand_dat();
    logic [AXI_NET_BITS-1:0] d;
    for (int i = 0; i < AXI_NET_BITS / 32; i++) d[i*32 +: 32] = $urandom();
    return d;
  endfunction

  // Model: ceil(len/64) beats per command, routed by opcode/actv, in command order.
  function automatic void plan_cmd(input logic [4:0] op, input logic actv, input int len,
                                   input int bad_idx);
    req_t     r;
    tb_beat_t b;
    int       nb;
    bit       rd;
    r.opcode = op;
    r.len    = LEN_BITS'(len);
    r.actv   = actv;
    cmd_q.push_back(r);
    rd = (op >= 5'h0D) && (op <= 5'h10);
    if (actv && !rd) exp_req.push_back(r);
    nb = (len + 63) / 64;
    for (int i = 0; i < nb; i++) begin
      b.dat  = rand_dat();
      b.keep = {$urandom(), $urandom()};
      b.last = (i == nb - 1);
      b.bad  = (i == bad_idx);
      beat_plan.push_back(b);
      if (actv && rd)  exp_rsp.push_back(b);
      if (actv && !rd) exp_wr.push_back(b);
    end
  endfunction

  function automatic void flush_model();
    cmd_q.delete();
    exp_req.delete();
    beat_plan.delete();
    exp_wr.delete();
    exp_rsp.delete();
    err_exp = 1'b0;
  endfunction

  function automatic logic pick(input int mode);
    if (mode == 0) return 1'b1;
    if (mode == 1) return ($urandom_range(0, 1) == 1);
    return 1'b0;
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge aclk);
    #2;
  endtask

  task automatic snap();
    b_wr = wr_beats; b_rsp = rsp_beats; b_req = req_cnt; b_hs = hs_cnt;
  endtask

  task automatic drain(input string tag, input int limit);
    int n = 0;
    while ((cmd_q.size() + beat_plan.size() + exp_wr.size() + exp_rsp.size()
            + exp_req.size()) != 0 && n < limit) begin
      step(1);
      n++;
    end
    chk(tag, (n < limit), 1'b1);
    step(3);
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_req_ready"},  s_req_net.ready, 1'b0);
    chk({tag, "_tready"},     s_axis_net.tready, 1'b0);
    chk({tag, "_req_valid"},  m_req_user.valid, 1'b0);
    chk({tag, "_wr_tvalid"},  m_axis_user_wr.tvalid, 1'b0);
    chk({tag, "_rsp_tvalid"}, m_axis_user_rsp.tvalid, 1'b0);
    chk({tag, "_err_len"},    err_len, 1'b0);
  endtask

  initial forever #5 aclk = ~aclk;
  always @(posedge aclk) cyc <= cyc + 1;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Command driver
  initial begin
    bit took;
    s_req_net.valid = 1'b0;
    s_req_net.data  = '0;
    forever begin
      @(negedge aclk);
      took = s_req_net.valid && s_req_net.ready;
      @(posedge aclk);
      #1;
      if (took && cmd_q.size() != 0) begin
        cmd_q.delete(0);
        cmd_acc++;
      end
      if (cmd_en && cmd_q.size() != 0 && (!gaps || $urandom_range(0, 3) != 0)) begin
        s_req_net.valid = 1'b1;
        s_req_net.data  = cmd_q[0];
      end else begin
        s_req_net.valid = 1'b0;
      end
    end
  end

  // Payload driver
  initial begin
    bit took;
    s_axis_net.tvalid = 1'b0;
    s_axis_net.tdata  = '0;
    s_axis_net.tkeep  = '0;
    s_axis_net.tlast  = 1'b0;
    forever begin
      @(negedge aclk);
      took = s_axis_net.tvalid && s_axis_net.tready;
      @(posedge aclk);
      #1;
      if (took && beat_plan.size() != 0) beat_plan.delete(0);
      if (data_en && beat_plan.size() != 0 && (!gaps || $urandom_range(0, 3) != 0)) begin
        s_axis_net.tvalid = 1'b1;
        s_axis_net.tdata  = beat_plan[0].dat;
        s_axis_net.tkeep  = beat_plan[0].keep;
        s_axis_net.tlast  = beat_plan[0].last ^ beat_plan[0].bad;
      end else begin
        s_axis_net.tvalid = 1'b0;
      end
    end
  end

  // Downstream ready driver
  initial begin
    m_axis_user_wr.tready  = 1'b0;
    m_axis_user_rsp.tready = 1'b0;
    m_req_user.ready       = 1'b0;
    forever begin
      @(posedge aclk);
      #1;
      m_axis_user_wr.tready  = pick(wr_mode);
      m_axis_user_rsp.tready = pick(rsp_mode);
      m_req_user.ready       = pick(req_mode);
    end
  end

  // Monitors / scoreboard
  always @(negedge aclk) begin
    if (aresetn) begin
      chk("err_len", err_len, err_exp);
      if (s_axis_net.tvalid && s_axis_net.tready) begin
        hs_cnt++;
        hs_cyc.push_back(cyc);
        if (beat_plan.size() != 0 && beat_plan[0].bad) err_exp = 1'b1;
      end
      if (m_axis_user_wr.tvalid && m_axis_user_wr.tready) begin
        wr_beats++;
        if (exp_wr.size() == 0) chk("wr_unexpected", m_axis_user_wr.tvalid, 1'b0);
        else begin
          e_wr = exp_wr.pop_front();
          chk("wr_tdata", m_axis_user_wr.tdata, e_wr.dat);
          chk("wr_tkeep", m_axis_user_wr.tkeep, e_wr.keep);
          chk("wr_tlast", m_axis_user_wr.tlast, e_wr.last);
        end
      end
      if (m_axis_user_rsp.tvalid && m_axis_user_rsp.tready) begin
        rsp_beats++;
        if (exp_rsp.size() == 0) chk("rsp_unexpected", m_axis_user_rsp.tvalid, 1'b0);
        else begin
          e_rsp = exp_rsp.pop_front();
          chk("rsp_tdata", m_axis_user_rsp.tdata, e_rsp.dat);
          chk("rsp_tkeep", m_axis_user_rsp.tkeep, e_rsp.keep);
          chk("rsp_tlast", m_axis_user_rsp.tlast, e_rsp.last);
        end
      end
      if (m_req_user.valid && m_req_user.ready) begin
        req_cnt++;
        if (exp_req.size() == 0) chk("req_unexpected", m_req_user.valid, 1'b0);
        else begin
          e_req = exp_req.pop_front();
          chk("req_data", AXI_NET_BITS'(m_req_user.data), AXI_NET_BITS'(e_req));
        end
      end
    end
  end

  initial begin
    int len, nb, bad, span, n;

    // Reset state
    aresetn = 1'b0;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    reset_checks("rst");
    @(posedge aclk);
    #2 aresetn = 1'b1;
    step(2);

    // Single WR, 256 B -> 4 beats, one user command
    snap();
    plan_cmd(OP_WR, 1'b1, 256, -1);
    drain("wr256_drain", 500);
    chk("wr256_wr_beats", wr_beats - b_wr, 4);
    chk("wr256_rsp_beats", rsp_beats - b_rsp, 0);
    chk("wr256_req", req_cnt - b_req, 1);

    // RSP 100 B then WR 64 B with no gap between packets
    snap();
    data_en = 1'b0;
    plan_cmd(OP_RSP, 1'b1, 100, -1);
    plan_cmd(OP_WR, 1'b1, 64, -1);
    step(6);
    hs_cyc.delete();
    data_en = 1'b1;
    drain("b2b_drain", 500);
    span = (hs_cyc.size() >= 3) ? hs_cyc[2] - hs_cyc[0] : -1;
    chk("b2b_in_beats", hs_cyc.size(), 3);
    chk("b2b_span", span, 2);
    chk("b2b_rsp_beats", rsp_beats - b_rsp, 2);
    chk("b2b_wr_beats", wr_beats - b_wr, 1);
    chk("b2b_req", req_cnt - b_req, 1);

    // Duplicate (actv=0), 128 B -> 2 beats consumed, nothing out
    snap();
    plan_cmd(OP_WR, 1'b0, 128, -1);
    drain("drop_drain", 500);
    chk("drop_in_beats", hs_cnt - b_hs, 2);
    chk("drop_wr_beats", wr_beats - b_wr, 0);
    chk("drop_rsp_beats", rsp_beats - b_rsp, 0);
    chk("drop_req", req_cnt - b_req, 0);

    // WR 192 B with early input tlast on beat 2
    snap();
    plan_cmd(OP_WR, 1'b1, 192, 1);
    drain("badlast_drain", 500);
    chk("badlast_wr_beats", wr_beats - b_wr, 3);
    @(negedge aclk);
    chk("badlast_err_len", err_len, 1'b1);
    step(1);

    // 1 KiB WR with user write path stalled for 40 cycles
    snap();
    wr_mode = 2;
    plan_cmd(OP_WR, 1'b1, 1024, -1);
    step(40);
    chk("stall_wr_beats_held", wr_beats - b_wr, 0);
    wr_mode = 0;
    drain("stall_drain", 1000);
    chk("stall_wr_beats", wr_beats - b_wr, 16);

    // Randomized mix
    gaps = 1'b1;
    wr_mode = 1; rsp_mode = 1; req_mode = 1;
    for (int i = 0; i < 150; i++) begin
      len = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 400);
      nb  = (len + 63) / 64;
      bad = (nb > 0 && $urandom_range(0, 9) == 0) ? $urandom_range(0, nb - 1) : -1;
      plan_cmd(($urandom_range(0, 1) == 1) ? 5'($urandom_range(13, 16)) : 5'($urandom_range(0, 31)),
               ($urandom_range(0, 4) != 0), len, bad);
    end
    drain("rand_drain", 30000);
    gaps = 1'b0;
    wr_mode = 0; rsp_mode = 0; req_mode = 0;

    // Queue full: FSM holds one popped entry, queue holds TB_OST, the next stalls
    data_en = 1'b0;
    b_hs = cmd_acc;
    for (int i = 0; i < TB_OST + 2; i++) plan_cmd(OP_WR, 1'b1, 128, -1);
    step(20);
    chk("full_accepted", cmd_acc - b_hs, TB_OST + 1);
    @(negedge aclk);
    chk("full_stall_valid", s_req_net.valid, 1'b1);
    chk("full_stall_ready", s_req_net.ready, 1'b0);
    step(1);

    // Reset in the middle of a packet
    b_hs = hs_cnt;
    data_en = 1'b1;
    n = 0;
    while (hs_cnt == b_hs && n < 100) begin
      step(1);
      n++;
    end
    chk("mid_first_beat", (hs_cnt != b_hs), 1'b1);
    aresetn = 1'b0;
    flush_model();
    step(1);
    @(negedge aclk);
    reset_checks("midrst");
    step(2);
    aresetn = 1'b1;
    step(2);
    snap();
    plan_cmd(OP_WR, 1'b1, 64, -1);
    drain("post_rst_drain", 500);
    chk("post_rst_wr_beats", wr_beats - b_wr, 1);
    chk("post_rst_req", req_cnt - b_req, 1);
    chk("post_rst_err_len", err_len, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
